// File: rtl/uart_tx_ext_if.sv
// Stream input bundle for uart_tx_ext: one data word plus a valid/ready pair.
// Handshake: a word moves on every rising clk edge where tvalid and tready are both 1;
// the source holds tdata/tvalid stable until that edge, and tready never depends on tvalid.
interface uart_tx_ext_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_tx_ext.sv
// UART transmitter fed from a stream input through a small FIFO, with selectable
// parity and stop-bit count; queued frames are sent back-to-back with no idle gap.
module uart_tx_ext #(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_ext_if.slave     s_axis,
  output logic             tx_wire,
  output logic             tx_busy,
  output logic [LVL_W-1:0] fifo_level,
  output logic [2:0]       state_dbg
);
  localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W      = $clog2(BIT_PERIOD);
  localparam int BIT_W      = $clog2(DATA_WIDTH + 1);
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] LAST_BAUD = CNT_W'(BIT_PERIOD - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(FIFO_DEPTH);
  localparam logic             ODD_PAR   = (PARITY_MODE == 2);
  localparam logic             HAS_PAR   = (PARITY_MODE != 0);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic [2:0]            state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_bit;
  logic                  ready_q;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [DATA_WIDTH-1:0] head;
  logic                  push;
  logic                  pop;
  logic                  bit_end;
  logic                  last_stop;
  logic [LVL_W-1:0]      level_next;

  assign head       = mem[rd_ptr];
  assign push       = s_axis.tvalid && ready_q;
  assign bit_end    = (baud_cnt == LAST_BAUD);
  assign last_stop  = (state == STOP) && bit_end && (bit_cnt == LAST_STOP);
  // The FSM only takes a word when one is queued, so the FIFO never underflows.
  assign pop        = (fifo_level != '0) && ((state == IDLE) || last_stop);
  assign level_next = fifo_level + LVL_W'(push) - LVL_W'(pop);

  assign s_axis.tready = ready_q;
  assign tx_busy       = (state != IDLE);
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_axis.tdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ready_q    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_level <= level_next;
      ready_q    <= (level_next < FULL_LVL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx_wire  <= 1'b1;
    end else begin
      if (pop) begin
        shift   <= head;
        par_bit <= (^head) ^ ODD_PAR;
      end
      baud_cnt <= (state == IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE: begin
          tx_wire <= 1'b1;
          if (pop) begin
            state   <= START;
            tx_wire <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            bit_cnt <= '0;
            tx_wire <= shift[0];
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              state   <= HAS_PAR ? PARITY : STOP;
              tx_wire <= HAS_PAR ? par_bit : 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shift   <= shift >> 1;
              tx_wire <= shift[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state   <= STOP;
            bit_cnt <= '0;
            tx_wire <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= pop ? START : IDLE;
              tx_wire <= !pop;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          tx_wire <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_ext.sv
// Bench for uart_tx_ext: five instances with different frame formats, a vector table of
// single frames, plus burst/backpressure, two-stop-bit queueing and mid-frame reset sequences.
module tb_uart_tx_ext;
  localparam int BIT_P = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [4:0] tx_v;
  logic [4:0] busy_v;
  logic [4:0] rdy_v;
  logic [2:0] lvl_v [5];
  logic [2:0] st_v [5];

  uart_tx_ext_if #(.DATA_WIDTH(8)) if_a ();
  uart_tx_ext_if #(.DATA_WIDTH(8)) if_b ();
  uart_tx_ext_if #(.DATA_WIDTH(8)) if_c ();
  uart_tx_ext_if #(.DATA_WIDTH(5)) if_d ();
  uart_tx_ext_if #(.DATA_WIDTH(8)) if_e ();

  assign rdy_v[0] = if_a.tready;
  assign rdy_v[1] = if_b.tready;
  assign rdy_v[2] = if_c.tready;
  assign rdy_v[3] = if_d.tready;
  assign rdy_v[4] = if_e.tready;

  // 8N1
  uart_tx_ext #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .PARITY_MODE(0),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst(rst), .s_axis(if_a.slave), .tx_wire(tx_v[0]), .tx_busy(busy_v[0]),
    .fifo_level(lvl_v[0]), .state_dbg(st_v[0]));
  // 8E1
  uart_tx_ext #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .PARITY_MODE(1),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .s_axis(if_b.slave), .tx_wire(tx_v[1]), .tx_busy(busy_v[1]),
    .fifo_level(lvl_v[1]), .state_dbg(st_v[1]));
  // 8N2
  uart_tx_ext #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .PARITY_MODE(0),
                .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .rst(rst), .s_axis(if_c.slave), .tx_wire(tx_v[2]), .tx_busy(busy_v[2]),
    .fifo_level(lvl_v[2]), .state_dbg(st_v[2]));
  // 5O1
  uart_tx_ext #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(5), .PARITY_MODE(2),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_d (
    .clk(clk), .rst(rst), .s_axis(if_d.slave), .tx_wire(tx_v[3]), .tx_busy(busy_v[3]),
    .fifo_level(lvl_v[3]), .state_dbg(st_v[3]));
  // 8O1
  uart_tx_ext #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_WIDTH(8), .PARITY_MODE(2),
                .STOP_BITS(1), .FIFO_DEPTH(4)) dut_e (
    .clk(clk), .rst(rst), .s_axis(if_e.slave), .tx_wire(tx_v[4]), .tx_busy(busy_v[4]),
    .fifo_level(lvl_v[4]), .state_dbg(st_v[4]));

  typedef struct {
    int          sel;
    logic [8:0]  data;
    logic [15:0] bits;   // line levels, bit 0 = start bit, one entry per bit period
    int          nbits;
  } vec_t;

  vec_t vecs [8];

  logic [7:0]  bw [6];
  int          acc_edge [6];
  int          idx;
  logic        acc;
  logic [63:0] exp_bits;
  int          bad_idle;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic set_src(input int sel, input logic v, input logic [8:0] d);
    case (sel)
      0: begin if_a.tvalid = v; if_a.tdata = d[7:0]; end
      1: begin if_b.tvalid = v; if_b.tdata = d[7:0]; end
      2: begin if_c.tvalid = v; if_c.tdata = d[7:0]; end
      3: begin if_d.tvalid = v; if_d.tdata = d[4:0]; end
      default: begin if_e.tvalid = v; if_e.tdata = d[7:0]; end
    endcase
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input int sel, input logic [8:0] d);
    int n;
    n = 0;
    set_src(sel, 1'b1, d);
    while (!rdy_v[sel] && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_timeout", rdy_v[sel], 1);
    @(posedge clk);
    @(negedge clk);
    set_src(sel, 1'b0, 9'h0);
  endtask

  // Samples one cycle per call step, starting at the current negedge.
  task automatic check_line(input int sel, input logic [63:0] exp, input int nbits, input int tag);
    int bad;
    int bad_busy;
    bad_busy = 0;
    for (int b = 0; b < nbits; b++) begin
      bad = 0;
      for (int k = 0; k < BIT_P; k++) begin
        if (tx_v[sel] !== exp[b]) bad++;
        if (busy_v[sel] !== 1'b1) bad_busy++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
        failures++;
        $display("FAIL line tag=%0d bit=%0d: %0d of %0d cycles differ from required level %b",
                 tag, b, bad, BIT_P, exp[b]);
      end
    end
    chk($sformatf("busy_during_frame tag=%0d low_cycles", tag), bad_busy, 0);
  endtask

  task automatic run_frame(input int sel, input logic [8:0] d, input logic [63:0] exp,
                           input int nbits, input int tag);
    send(sel, d);
    chk($sformatf("queued_level tag=%0d", tag), lvl_v[sel], 1);
    chk($sformatf("idle_before_start tag=%0d", tag), tx_v[sel], 1);
    chk($sformatf("busy_before_start tag=%0d", tag), busy_v[sel], 0);
    @(negedge clk);
    chk($sformatf("level_after_pop tag=%0d", tag), lvl_v[sel], 0);
    check_line(sel, exp, nbits, tag);
    chk($sformatf("idle_after_frame tag=%0d", tag), tx_v[sel], 1);
    chk($sformatf("busy_after_frame tag=%0d", tag), busy_v[sel], 0);
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [9:0] frame8n1(input logic [7:0] d);
    return {1'b1, d, 1'b0};
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 9'h0A5, 16'h034A, 10};
    vecs[1] = '{1, 9'h007, 16'h060E, 11};
    vecs[2] = '{4, 9'h007, 16'h040E, 11};
    vecs[3] = '{1, 9'h000, 16'h0400, 11};
    vecs[4] = '{3, 9'h01F, 16'h00BE, 8};
    vecs[5] = '{3, 9'h007, 16'h008E, 8};
    vecs[6] = '{2, 9'h05A, 16'h06B4, 11};
    vecs[7] = '{0, 9'h0FF, 16'h03FE, 10};
    bw = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h55, 8'hC3};

    for (int s = 0; s < 5; s++) set_src(s, 1'b0, 9'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 5; s++) begin
      chk($sformatf("reset_tx sel=%0d", s), tx_v[s], 1);
      chk($sformatf("reset_busy sel=%0d", s), busy_v[s], 0);
      chk($sformatf("reset_level sel=%0d", s), lvl_v[s], 0);
      chk($sformatf("reset_ready sel=%0d", s), rdy_v[s], 1);
      chk($sformatf("reset_state sel=%0d", s), st_v[s], 0);
    end

    for (int i = 0; i < 8; i++)
      run_frame(vecs[i].sel, vecs[i].data, 64'(vecs[i].bits), vecs[i].nbits, i);

    // Burst of six words into 8N1 with a four-entry FIFO.
    exp_bits = '0;
    for (int i = 0; i < 6; i++) exp_bits = exp_bits | (64'(frame8n1(bw[i])) << (10 * i));
    for (int i = 0; i < 6; i++) acc_edge[i] = -1;
    idx = 0;
    set_src(0, 1'b1, 9'(bw[0]));
    fork
      begin
        for (int c = 0; c < 400 && idx < 6; c++) begin
          if (c == 5) begin
            chk("burst_ready_low", rdy_v[0], 0);
            chk("burst_level_full", lvl_v[0], 4);
          end
          acc = rdy_v[0];
          @(posedge clk);
          if (acc) begin
            acc_edge[idx] = c;
            idx++;
          end
          @(negedge clk);
          if (idx < 6) set_src(0, 1'b1, 9'(bw[idx]));
          else set_src(0, 1'b0, 9'h0);
        end
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check_line(0, exp_bits, 60, 100);
      end
    join
    set_src(0, 1'b0, 9'h0);
    for (int i = 0; i < 5; i++) chk($sformatf("burst_accept_edge word=%0d", i), acc_edge[i], i);
    // Ready is registered, so the sixth word lands one edge after the second pop (edge 101).
    chk("burst_accept_edge word=5", acc_edge[5], 102);
    chk("burst_idle_after", tx_v[0], 1);
    chk("burst_busy_after", busy_v[0], 0);
    chk("burst_level_after", lvl_v[0], 0);
    repeat (3) @(negedge clk);

    // Two stop bits, two queued words: second start bit follows 20 high cycles.
    exp_bits = 64'({2'b11, 8'h5A, 1'b0}) | (64'({2'b11, 8'hC3, 1'b0}) << 11);
    send(2, 9'h05A);
    set_src(2, 1'b1, 9'h0C3);
    @(negedge clk);
    set_src(2, 1'b0, 9'h0);
    chk("stop2_level_push_pop", lvl_v[2], 1);
    check_line(2, exp_bits, 22, 200);
    chk("stop2_idle_after", tx_v[2], 1);
    chk("stop2_busy_after", busy_v[2], 0);
    repeat (3) @(negedge clk);

    // Reset at cycle 35 of a frame with two words queued.
    send(0, 9'h000);
    set_src(0, 1'b1, 9'h081);
    @(negedge clk);
    set_src(0, 1'b1, 9'h07E);
    @(negedge clk);
    set_src(0, 1'b0, 9'h0);
    chk("rst_pre_level", lvl_v[0], 2);
    repeat (34) @(negedge clk);
    chk("rst_pre_tx_data_bit", tx_v[0], 0);
    rst = 1'b1;
    #1;
    chk("rst_async_tx", tx_v[0], 1);
    chk("rst_async_busy", busy_v[0], 0);
    chk("rst_async_level", lvl_v[0], 0);
    chk("rst_async_ready", rdy_v[0], 1);
    chk("rst_async_state", st_v[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad_idle = 0;
    for (int k = 0; k < 150; k++) begin
      @(negedge clk);
      if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad_idle++;
    end
    chk("rst_discarded_words_not_sent", bad_idle, 0);
    run_frame(0, 9'h03C, 64'(frame8n1(8'h3C)), 10, 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
